// File: rtl/etherparse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : etherparse_pkg
//  Description : Shared types and constants for the Ethernet ingress parser.
//  Revision    : 1.0  initial release
// ============================================================================
package etherparse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        OVER   = 2'd2
    } tracker_state_e;

    localparam int ETH_MIN_FRAME_BYTES  = 60;
    localparam int ETH_MAX_JUMBO_BYTES  = 9018;
    localparam int ETH_L2_HDR_MAX_BYTES = 18;

    // Width of a byte counter that may overshoot the maximum by one full beat.
    function automatic int cnt_width(input int max_bytes, input int lanes);
        return $clog2(max_bytes + lanes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_byte_tracker_keep_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : keep_popcount
//  Description : Combinational byte-enable population count and contiguity test.
//  Revision    : 1.0  initial release
// ============================================================================
module keep_popcount #(
    parameter  int LANES = 8,
    localparam int CNT_W = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] keep,
    output logic [CNT_W-1:0] count,
    output logic             contig
);

    logic [LANES:0] w_inc;

    always_comb begin
        count = '0;
        for (int i = 0; i < LANES; i++) begin
            count = count + CNT_W'(keep[i]);
        end
    end

    // 0..01..1 plus one is a power of two, so it shares no set bits with keep.
    assign w_inc  = {1'b0, keep} + (LANES + 1)'(1);
    assign contig = (|keep) && (({1'b0, keep} & w_inc) == '0);

endmodule
`default_nettype wire

// File: rtl/frame_byte_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : frame_byte_tracker
//  Description : Keep-aware byte position tracker with windows and frame
//                length classification. Optional counters: FRAME_BYTE_TRACKER_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_byte_tracker
    import etherparse_pkg::*;
#(
    parameter  int DATA_WIDTH      = 64,
    parameter  int MAX_FRAME_BYTES = ETH_MAX_JUMBO_BYTES,
    parameter  int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
    parameter  int NUM_WINDOWS     = 4,
    localparam int LANES           = DATA_WIDTH / 8,
    localparam int CW              = cnt_width(MAX_FRAME_BYTES, LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    input  logic                      s_ready,
    input  logic [LANES-1:0]          s_keep,
    input  logic                      s_last,
    input  logic [NUM_WINDOWS*CW-1:0] win_start,
    input  logic [NUM_WINDOWS*CW-1:0] win_end,
    output logic [CW-1:0]             byte_offset,
    output logic [NUM_WINDOWS-1:0]    win_hit,
    output logic [CW-1:0]             frame_len,
    output logic                      frame_len_valid,
    output logic                      runt,
    output logic                      oversize,
`ifdef FRAME_BYTE_TRACKER_STATS_EN
    output logic [31:0]               stat_frames,
    output logic [31:0]               stat_runts,
    output logic [31:0]               stat_oversize,
    output logic [31:0]               stat_keep_err,
`endif
    output logic                      keep_err
);

    localparam int PCW = $clog2(LANES + 1);

    logic [PCW-1:0]  w_pc;
    logic            w_contig;
    logic            w_acc;
    logic            w_beat_err;
    logic [CW:0]     w_sum;
    logic [CW-1:0]   w_sum_sat;
    logic            w_over;
    logic [CW:0]     w_end_pos;

    tracker_state_e  state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [CW-1:0]   len_q;
    logic            flv_q, runt_q, over_q, kerr_q;

    keep_popcount #(.LANES(LANES)) u_popcount (
        .keep   (s_keep),
        .count  (w_pc),
        .contig (w_contig)
    );

    assign w_acc      = s_valid & s_ready;
    assign w_beat_err = s_last ? ~w_contig : (s_keep != '1);
    assign w_sum      = {1'b0, cnt_q} + (CW + 1)'(w_pc);
    assign w_sum_sat  = w_sum[CW] ? '1 : w_sum[CW-1:0];
    assign w_over     = (w_sum_sat > CW'(MAX_FRAME_BYTES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (w_acc) begin
            if (s_last) begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end else begin
                cnt_d = w_sum_sat;
                err_d = err_q | w_beat_err;
                case (state_q)
                    IDLE, ACTIVE: state_d = w_over ? OVER : ACTIVE;
                    OVER:         state_d = OVER;
                    default:      state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            len_q   <= '0;
            flv_q   <= 1'b0;
            runt_q  <= 1'b0;
            over_q  <= 1'b0;
            kerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            flv_q   <= w_acc & s_last;
            if (w_acc && s_last) begin
                len_q  <= w_sum_sat;
                runt_q <= (w_sum_sat < CW'(MIN_FRAME_BYTES));
                over_q <= w_over | (state_q == OVER);
                kerr_q <= err_q | w_beat_err;
            end
        end
    end

    assign byte_offset     = (state_q == IDLE) ? '0 : cnt_q;
    assign frame_len       = len_q;
    assign frame_len_valid = flv_q;
    assign runt            = runt_q;
    assign oversize        = over_q;
    assign keep_err        = kerr_q;

    // First byte past the beat, so windows compare as half-open intervals.
    assign w_end_pos = {1'b0, byte_offset} + (CW + 1)'(w_pc);

    for (genvar i = 0; i < NUM_WINDOWS; i++) begin : g_win
        logic [CW-1:0] w_ws, w_we;
        assign w_ws       = win_start[i*CW +: CW];
        assign w_we       = win_end[i*CW +: CW];
        assign win_hit[i] = s_valid && (w_ws < w_we) && (byte_offset < w_we)
                            && (w_end_pos > {1'b0, w_ws});
    end

`ifdef FRAME_BYTE_TRACKER_STATS_EN
    logic [31:0] st_frames_q, st_runts_q, st_over_q, st_kerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_frames_q <= '0;
            st_runts_q  <= '0;
            st_over_q   <= '0;
            st_kerr_q   <= '0;
        end else if (flv_q) begin
            if (st_frames_q != '1)           st_frames_q <= st_frames_q + 32'd1;
            if (runt_q && st_runts_q != '1)  st_runts_q  <= st_runts_q + 32'd1;
            if (over_q && st_over_q != '1)   st_over_q   <= st_over_q + 32'd1;
            if (kerr_q && st_kerr_q != '1)   st_kerr_q   <= st_kerr_q + 32'd1;
        end
    end

    assign stat_frames   = st_frames_q;
    assign stat_runts    = st_runts_q;
    assign stat_oversize = st_over_q;
    assign stat_keep_err = st_kerr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_byte_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_byte_tracker
//  Description : Directed self-checking bench for frame_byte_tracker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_byte_tracker;

    localparam int DW    = 64;
    localparam int LANES = DW / 8;
    localparam int MAXB  = 9018;
    localparam int MINB  = 60;
    localparam int NW    = 4;
    localparam int CW    = $clog2(MAXB + LANES + 1);
    localparam int SATV  = (1 << CW) - 1;

    logic               clk;
    logic               rst_n;
    logic               s_valid, s_ready, s_last;
    logic [LANES-1:0]   s_keep;
    logic [NW*CW-1:0]   win_start, win_end;
    logic [CW-1:0]      byte_offset;
    logic [NW-1:0]      win_hit;
    logic [CW-1:0]      frame_len;
    logic               frame_len_valid, runt, oversize, keep_err;
`ifdef FRAME_BYTE_TRACKER_STATS_EN
    logic [31:0]        stat_frames, stat_runts, stat_oversize, stat_keep_err;
`endif

    frame_byte_tracker #(
        .DATA_WIDTH      (DW),
        .MAX_FRAME_BYTES (MAXB),
        .MIN_FRAME_BYTES (MINB),
        .NUM_WINDOWS     (NW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_keep          (s_keep),
        .s_last          (s_last),
        .win_start       (win_start),
        .win_end         (win_end),
        .byte_offset     (byte_offset),
        .win_hit         (win_hit),
        .frame_len       (frame_len),
        .frame_len_valid (frame_len_valid),
        .runt            (runt),
        .oversize        (oversize),
`ifdef FRAME_BYTE_TRACKER_STATS_EN
        .stat_frames     (stat_frames),
        .stat_runts      (stat_runts),
        .stat_oversize   (stat_oversize),
        .stat_keep_err   (stat_keep_err),
`endif
        .keep_err        (keep_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: offset is the sum of accepted byte counts so far in the frame.
    int  m_off, m_len, pc;
    bit  m_err, m_vld, m_runt, m_over, m_kerr, contig, e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_off = 0; m_len = 0; m_err = 0; m_vld = 0;
            m_runt = 0; m_over = 0; m_kerr = 0;
        end else begin
            m_vld = 0;
            if (s_valid && s_ready) begin
                pc     = $countones(s_keep);
                contig = (pc > 0) && (int'(s_keep) == ((1 << pc) - 1));
                e      = s_last ? !contig : (s_keep != 8'hFF);
                if (s_last) begin
                    m_len  = (m_off + pc > SATV) ? SATV : m_off + pc;
                    m_runt = (m_len < MINB);
                    m_over = (m_len > MAXB);
                    m_kerr = m_err | e;
                    m_vld  = 1;
                    m_off  = 0;
                    m_err  = 0;
                end else begin
                    m_off = (m_off + pc > SATV) ? SATV : m_off + pc;
                    m_err = m_err | e;
                end
            end
        end
    end

    typedef struct {
        int len;
        bit runt;
        bit over;
        bit kerr;
    } pulse_t;
    pulse_t pq[$];

`ifdef FRAME_BYTE_TRACKER_STATS_EN
    int ms_frames, ms_runts, ms_over, ms_kerr;
`endif

    always @(negedge clk) begin
        if (rst_n) begin
            logic [NW-1:0] exp_hit;
            int ws, we, npc;
            npc = $countones(s_keep);
            for (int i = 0; i < NW; i++) begin
                ws = int'(win_start[i*CW +: CW]);
                we = int'(win_end[i*CW +: CW]);
                exp_hit[i] = s_valid && (ws < we) && (m_off < we) && (m_off + npc > ws);
            end
            chk("byte_offset", byte_offset, m_off);
            chk("win_hit", win_hit, exp_hit);
            chk("frame_len_valid", frame_len_valid, m_vld);
            chk("frame_len", frame_len, m_len);
            chk("runt", runt, m_runt);
            chk("oversize", oversize, m_over);
            chk("keep_err", keep_err, m_kerr);
            if (frame_len_valid)
                pq.push_back('{len: int'(frame_len), runt: runt, over: oversize, kerr: keep_err});
`ifdef FRAME_BYTE_TRACKER_STATS_EN
            chk("stat_frames", stat_frames, ms_frames);
            chk("stat_runts", stat_runts, ms_runts);
            chk("stat_oversize", stat_oversize, ms_over);
            chk("stat_keep_err", stat_keep_err, ms_kerr);
            if (m_vld) begin
                ms_frames++;
                if (m_runt) ms_runts++;
                if (m_over) ms_over++;
                if (m_kerr) ms_kerr++;
            end
        end else begin
            ms_frames = 0; ms_runts = 0; ms_over = 0; ms_kerr = 0;
`endif
        end
    end

    task automatic set_win(input int i, input int s, input int en);
        win_start[i*CW +: CW] = CW'(s);
        win_end[i*CW +: CW]   = CW'(en);
    endtask

    task automatic beat(input logic [7:0] k, input bit l, input int exp_off,
                        input logic [3:0] exp_hit, input bit do_chk);
        s_valid = 1'b1; s_ready = 1'b1; s_keep = k; s_last = l;
        #2;
        if (do_chk) begin
            chk("lit_offset", byte_offset, exp_off);
            chk("lit_win_hit", win_hit, exp_hit);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_last = 1'b0; s_keep = '0;
        @(posedge clk); #1;
    endtask

    task automatic check_pulse(input string name, input int len, input bit r,
                               input bit o, input bit k);
        pulse_t p;
        compared++;
        if (pq.size() == 0) begin
            mismatched++;
            $display("FAIL %s_pulse: got 0 pulses, expected 1", name);
        end else begin
            p = pq.pop_front();
            chk({name, "_len"}, p.len, len);
            chk({name, "_runt"}, 32'(p.runt), 32'(r));
            chk({name, "_oversize"}, 32'(p.over), 32'(o));
            chk({name, "_keep_err"}, 32'(p.kerr), 32'(k));
        end
    endtask

    logic [3:0] t1_hits [8];

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_ready = 1'b0; s_last = 1'b0; s_keep = '0;
        win_start = '0; win_end = '0;
        set_win(0, 12, 14);
        set_win(1, 14, 18);
        set_win(2, 5, 5);
        set_win(3, 59, 64);
        #12;
        chk("rst_byte_offset", byte_offset, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_frame_len_valid", frame_len_valid, 0);
        chk("rst_runt", runt, 0);
        chk("rst_oversize", oversize, 0);
        chk("rst_keep_err", keep_err, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // 60-byte frame: seven full beats then keep 0x0F
        t1_hits = '{4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
        for (int b = 0; b < 7; b++) beat(8'hFF, 1'b0, b * 8, t1_hits[b], 1'b1);
        beat(8'h0F, 1'b1, 56, t1_hits[7], 1'b1);
        idle();
        check_pulse("t1", 60, 1'b0, 1'b0, 1'b0);

        // single-beat frame then an immediate 22-byte frame
        beat(8'hFF, 1'b1, 0, 4'b0000, 1'b1);
        beat(8'hFF, 1'b0, 0, 4'b0000, 1'b1);
        beat(8'hFF, 1'b0, 8, 4'b0011, 1'b1);
        beat(8'h3F, 1'b1, 16, 4'b0010, 1'b1);
        idle();
        check_pulse("t2a", 8, 1'b1, 1'b0, 1'b0);
        check_pulse("t2b", 22, 1'b1, 1'b0, 1'b0);

        // 9100-byte oversize frame
        for (int n = 0; n < 1137; n++) beat(8'hFF, 1'b0, n * 8, 4'b0000, 1'b0);
        beat(8'h0F, 1'b1, 9096, 4'b0000, 1'b1);
        idle();
        check_pulse("t3", 9100, 1'b0, 1'b1, 1'b0);

        // stall mid-frame, then a non-contiguous beat
        beat(8'hFF, 1'b0, 0, 4'b0000, 1'b1);
        beat(8'hFF, 1'b0, 8, 4'b0011, 1'b1);
        for (int n = 0; n < 5; n++) begin
            s_valid = 1'b1; s_ready = 1'b0; s_keep = 8'hFF; s_last = 1'b0;
            #2 chk("stall_offset", byte_offset, 16);
            @(posedge clk); #1;
        end
        beat(8'hF5, 1'b0, 16, 4'b0010, 1'b1);
        for (int n = 0; n < 4; n++) beat(8'hFF, 1'b0, 22 + n * 8, 4'b0000, 1'b1);
        beat(8'hFF, 1'b1, 54, 4'b1000, 1'b1);
        idle();
        check_pulse("t4", 62, 1'b0, 1'b0, 1'b1);

        // zero keep on the last beat
        beat(8'hFF, 1'b0, 0, 4'b0000, 1'b1);
        beat(8'h00, 1'b1, 8, 4'b0000, 1'b1);
        idle();
        check_pulse("t6", 8, 1'b1, 1'b0, 1'b1);

        // reset mid-frame, then a clean 64-byte frame
        beat(8'hFF, 1'b0, 0, 4'b0000, 1'b1);
        beat(8'hFF, 1'b0, 8, 4'b0011, 1'b1);
        beat(8'hFF, 1'b0, 16, 4'b0010, 1'b1);
        s_valid = 1'b0; s_last = 1'b0; s_keep = '0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_frame_len", frame_len, 0);
        chk("midrst_byte_offset", byte_offset, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_no_pulse", pq.size(), 0);
        for (int b = 0; b < 7; b++) beat(8'hFF, 1'b0, b * 8, t1_hits[b], b < 3);
        beat(8'hFF, 1'b1, 56, 4'b1000, 1'b1);
        idle();
        check_pulse("t5", 64, 1'b0, 1'b0, 1'b0);
        chk("no_extra_pulse", pq.size(), 0);
`ifdef FRAME_BYTE_TRACKER_STATS_EN
        chk("lit_stat_frames", stat_frames, 1);
        chk("lit_stat_runts", stat_runts, 0);
`endif
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
